// File: rtl/phoenix_data_memory_responder_if.sv
// phoenix_data_memory_responder_if: phoeniX data memory bus (core = master, memory = slave)
interface phoenix_data_memory_responder_if;
  logic        enable;
  logic        state;
  logic [31:0] address;
  logic [3:0]  frame_mask;
  wire  [31:0] data;
  modport master (output enable, state, address, frame_mask, inout data);
  modport slave  (input enable, state, address, frame_mask, inout data);
endinterface

// File: rtl/phoenix_data_memory_responder.sv
// phoenix_data_memory_responder: byte-maskable RAM plus console TX FIFO; `PHOENIX_DMEM_FAULT_EN adds access_fault
module phoenix_data_memory_responder #(
  parameter int          MEM_DEPTH    = 1048576,
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic       CLK,
  input  logic       reset,
  phoenix_data_memory_responder_if.slave bus,
  output logic       console_valid,
  output logic [7:0] console_data,
  input  logic       console_ready
`ifdef PHOENIX_DMEM_FAULT_EN
  ,
  output logic       access_fault
`endif
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [31:0]   r_mem  [MEM_DEPTH];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0]   r_cnt;
  logic          r_ovf, r_set, r_clr;
  logic [31:0]   r_rdata;
  logic [AW-1:0] w_idx;
  logic          w_con, w_wr, w_rd, w_ram_ok, w_full, w_empty, w_pop, w_push_req, w_push, w_ovf_set, w_stat_rd;
  assign w_idx      = AW'(bus.address >> 2);
  assign w_con      = bus.address == CONSOLE_ADDR;
  assign w_wr       = bus.enable & bus.state;
  assign w_rd       = bus.enable & ~bus.state;
  assign w_full     = r_cnt == (PW+1)'(FIFO_DEPTH);
  assign w_empty    = r_cnt == '0;
  assign w_pop      = console_valid & console_ready;
  assign w_push_req = w_wr & w_con & bus.frame_mask[3];
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovf_set  = w_push_req & w_full & ~w_pop;
  assign w_stat_rd  = w_rd & w_con;
`ifdef PHOENIX_DMEM_FAULT_EN
  logic w_oob, r_fault;
  assign w_oob    = (bus.address >> 2) >= 32'(MEM_DEPTH);
  assign w_ram_ok = ~w_con & ~w_oob;
  // Sticky flag for any non-console access beyond the RAM
  always_ff @(negedge CLK or negedge reset)
    if (!reset) r_fault <= 1'b0;
    else if (bus.enable & ~w_con & w_oob) r_fault <= 1'b1;
  assign access_fault = r_fault;
`else
  assign w_ram_ok = ~w_con;
`endif
  // RAM lane writes and read-word capture; contents survive reset
  always_ff @(negedge CLK) begin
    if (w_wr & w_ram_ok) begin
      if (bus.frame_mask[3]) r_mem[w_idx][7:0]   <= bus.data[7:0];
      if (bus.frame_mask[2]) r_mem[w_idx][15:8]  <= bus.data[15:8];
      if (bus.frame_mask[1]) r_mem[w_idx][23:16] <= bus.data[23:16];
      if (bus.frame_mask[0]) r_mem[w_idx][31:24] <= bus.data[31:24];
    end
    if (w_rd) r_rdata <= w_con ? {29'b0, r_ovf, w_empty, w_full} : w_ram_ok ? r_mem[w_idx] : 32'h0;
  end
  // Console FIFO byte storage
  always_ff @(negedge CLK)
    if (w_push) r_fifo[r_wp] <= bus.data[7:0];
  // FIFO pointers, occupancy and sticky overflow (a set beats a clearing status read)
  always_ff @(negedge CLK or negedge reset)
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
      r_ovf <= w_ovf_set | (r_ovf & ~w_stat_rd);
    end
  // Read launch: toggled on the falling edge, so the bus is driven while r_set differs from r_clr
  always_ff @(negedge CLK or negedge reset)
    if (!reset) r_set <= 1'b0;
    else if (w_rd) r_set <= ~r_set;
  // Read release: catching up on the rising edge ends the drive window
  always_ff @(posedge CLK or negedge reset)
    if (!reset) r_clr <= 1'b0;
    else r_clr <= r_set;
  assign bus.data      = (r_set ^ r_clr) ? r_rdata : 32'hz;
  assign console_valid = ~w_empty;
  assign console_data  = console_valid ? r_fifo[r_rp] : 8'h00;
endmodule

// File: tb/tb_phoenix_data_memory_responder.sv
// tb_phoenix_data_memory_responder: randomized checks of RAM, console FIFO and reset against a queue/array model
module tb_phoenix_data_memory_responder;
  localparam int          MEM_DEPTH = 1048576;
  localparam logic [31:0] CON       = 32'h1000_0000;
  logic        CLK, reset, console_ready, console_valid;
  logic [7:0]  console_data;
  logic        en, st, drv;
  logic [31:0] addr, wdata;
  logic [3:0]  mask;
  int          vec, err;
  logic [7:0]  q[$];
  logic        ovf;
  logic [31:0] mdl[int];
  phoenix_data_memory_responder_if bus();
  assign bus.enable     = en;
  assign bus.state      = st;
  assign bus.address    = addr;
  assign bus.frame_mask = mask;
  assign bus.data       = drv ? wdata : 32'hz;
`ifdef PHOENIX_DMEM_FAULT_EN
  logic access_fault;
`endif
  phoenix_data_memory_responder dut (
    .CLK(CLK), .reset(reset), .bus(bus),
    .console_valid(console_valid), .console_data(console_data), .console_ready(console_ready)
`ifdef PHOENIX_DMEM_FAULT_EN
    , .access_fault(access_fault)
`endif
  );
  always #5 CLK = ~CLK;
  // A bus nobody drives reads as Z, or as 0 on a two-state simulator
  function automatic bit released(input logic [31:0] v);
    return (v === 32'hz) || (v === 32'h0);
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
    merge = o;
    if (m[3]) merge[7:0]   = n[7:0];
    if (m[2]) merge[15:8]  = n[15:8];
    if (m[1]) merge[23:16] = n[23:16];
    if (m[0]) merge[31:24] = n[31:24];
  endfunction
  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'(MEM_DEPTH - 1));
  endfunction
  // One request starting at posedge+1: rd sampled just after the falling edge, after just after the next rising edge
  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                        output logic [31:0] rd, output logic [31:0] after);
    en = 1; st = w; addr = a; mask = m; wdata = d; drv = w;
    @(negedge CLK); #1;
    rd = bus.data;
    en = 0; drv = 0;
    @(posedge CLK); #1;
    after = bus.data;
  endtask
  task automatic ram_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    logic [31:0] rd, af;
    access(1, a, m, d, rd, af);
    mdl[widx(a)] = merge(mdl.exists(widx(a)) ? mdl[widx(a)] : 32'h0, d, m);
  endtask
  task automatic con_write(input logic [7:0] b);
    logic [31:0] rd, af;
    access(1, CON, 4'b1000, {24'hA5A5A5, b}, rd, af);
    if (q.size() == 8) ovf = 1; else q.push_back(b);
  endtask
  task automatic test_reset();
    logic [31:0] rd, af;
    repeat (2) @(posedge CLK); #1;
    vec++; if (!released(bus.data)) begin err++; $display("FAIL reset_bus: got %h expected z", bus.data); end
    vec++; if (console_valid !== 1'b0) begin err++; $display("FAIL reset_valid: got %b expected 0", console_valid); end
    vec++; if (console_data !== 8'h00) begin err++; $display("FAIL reset_data: got %h expected 00", console_data); end
`ifdef PHOENIX_DMEM_FAULT_EN
    vec++; if (access_fault !== 1'b0) begin err++; $display("FAIL reset_fault: got %b expected 0", access_fault); end
`endif
    reset = 1;
    access(0, CON, 4'hf, 0, rd, af);
    vec++; if (rd !== 32'h2) begin err++; $display("FAIL reset_status: got %h expected 00000002", rd); end
  endtask
  task automatic test_write_read();
    logic [31:0] rd, af;
    ram_write(32'h100, 4'b1111, 32'hDEADBEEF);
    access(0, 32'h100, 4'h0, 0, rd, af);
    vec++; if (rd !== 32'hDEADBEEF) begin err++; $display("FAIL rd_full: got %h expected deadbeef", rd); end
    vec++; if (!released(af)) begin err++; $display("FAIL rd_release: got %h expected z", af); end
    ram_write(32'h100, 4'b1000, 32'h000000AA);
    access(0, 32'h100, 4'h0, 0, rd, af);
    vec++; if (rd !== 32'hDEADBEAA) begin err++; $display("FAIL rd_lane3: got %h expected deadbeaa", rd); end
    ram_write(32'h100, 4'b0001, 32'h55000000);
    access(0, 32'h100, 4'h0, 0, rd, af);
    vec++; if (rd !== 32'h55ADBEAA) begin err++; $display("FAIL rd_lane0: got %h expected 55adbeaa", rd); end
  endtask
  task automatic test_random_ram();
    logic [31:0] rd, af, a;
    logic [31:0] pool[6];
    for (int i = 0; i < 6; i++) begin
      pool[i] = {$urandom_range(1, MEM_DEPTH - 1), 2'b00};
      ram_write(pool[i], 4'hf, $urandom);
    end
    for (int i = 0; i < 80; i++) begin
      a = pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) ram_write(a, 4'($urandom), $urandom);
      else begin
        access(0, a, 4'($urandom), 0, rd, af);
        vec++; if (rd !== mdl[widx(a)]) begin err++; $display("FAIL rand_rd @%h: got %h expected %h", a, rd, mdl[widx(a)]); end
        if (mdl[widx(a)] != 0) begin
          vec++; if (!released(af)) begin err++; $display("FAIL rand_release @%h: got %h expected z", a, af); end
        end
      end
    end
  endtask
  task automatic test_drain();
    console_ready = 1;
    while (q.size() != 0) begin
      vec++;
      if (console_valid !== 1'b1 || console_data !== q[0]) begin
        err++; $display("FAIL drain: got valid=%b data=%h expected valid=1 data=%h", console_valid, console_data, q[0]);
      end
      @(negedge CLK); #1;
      void'(q.pop_front());
    end
    console_ready = 0;
    vec++; if (console_valid !== 1'b0) begin err++; $display("FAIL drain_empty: got %b expected 0", console_valid); end
    @(posedge CLK); #1;
  endtask
  task automatic test_console();
    logic [31:0] rd, af;
    ram_write(32'h0, 4'hf, 32'hCAFE0001);
    con_write(8'h48);
    con_write(8'h69);
    vec++; if (console_valid !== 1'b1 || console_data !== 8'h48) begin
      err++; $display("FAIL con_head: got valid=%b data=%h expected valid=1 data=48", console_valid, console_data);
    end
    test_drain();
    access(0, 32'h0, 4'hf, 0, rd, af);
    vec++; if (rd !== 32'hCAFE0001) begin err++; $display("FAIL con_ram_untouched: got %h expected cafe0001", rd); end
    access(1, CON, 4'b0111, 32'h77, rd, af);
    vec++; if (console_valid !== 1'b0) begin err++; $display("FAIL con_nomask: got %b expected 0", console_valid); end
  endtask
  task automatic test_overflow();
    logic [31:0] rd, af;
    for (int i = 0; i < 9; i++) con_write(8'($urandom));
    access(0, CON, 4'hf, 0, rd, af);
    vec++; if (rd !== 32'h5) begin err++; $display("FAIL ovf_status1: got %h expected 00000005", rd); end
    ovf = 0;
    access(0, CON, 4'hf, 0, rd, af);
    vec++; if (rd !== 32'h1) begin err++; $display("FAIL ovf_status2: got %h expected 00000001", rd); end
    test_drain();
  endtask
  task automatic test_full_push_pop();
    logic [31:0] rd, af;
    for (int i = 0; i < 8; i++) con_write(8'(8'h10 + i));
    console_ready = 1;
    access(1, CON, 4'b1000, 32'hC3, rd, af);
    console_ready = 0;
    void'(q.pop_front());
    q.push_back(8'hC3);
    access(0, CON, 4'hf, 0, rd, af);
    vec++; if (rd !== 32'h1) begin err++; $display("FAIL full_pushpop_status: got %h expected 00000001", rd); end
    test_drain();
  endtask
  task automatic test_random_console();
    int op;
    logic [7:0] b;
    logic [31:0] exp_stat;
    logic pop;
    for (int i = 0; i < 200; i++) begin
      vec++;
      if (console_valid !== (q.size() != 0) || (q.size() != 0 && console_data !== q[0])) begin
        err++; $display("FAIL rand_con %0d: got valid=%b data=%h expected valid=%b data=%h",
                        i, console_valid, console_data, q.size() != 0, q.size() != 0 ? q[0] : 8'h00);
      end
      op = $urandom_range(0, 4);
      b = 8'($urandom);
      console_ready = ($urandom_range(0, 2) == 0);
      en = (op != 2); st = (op != 1); addr = CON; wdata = {24'($urandom), b}; drv = st & en;
      mask = (op == 3) ? 4'($urandom_range(0, 7)) : {1'b1, 3'($urandom)};
      exp_stat = {29'b0, ovf, q.size() == 0, q.size() == 8};
      @(negedge CLK); #1;
      if (op == 1) begin
        vec++; if (bus.data !== exp_stat) begin err++; $display("FAIL rand_status %0d: got %h expected %h", i, bus.data, exp_stat); end
        ovf = 0;
      end
      pop = console_ready && q.size() != 0;
      if ((op == 0 || op == 4) && q.size() == 8 && !pop) ovf = 1;
      else begin
        if (pop) void'(q.pop_front());
        if (op == 0 || op == 4) q.push_back(b);
      end
      en = 0; drv = 0;
      @(posedge CLK); #1;
    end
    console_ready = 0;
    test_drain();
    ovf = 0;
  endtask
  task automatic test_reset_mid_read();
    logic [31:0] rd, af;
    con_write(8'h31);
    con_write(8'h32);
    en = 1; st = 0; addr = 32'h100; mask = 4'hf; drv = 0;
    @(negedge CLK); #1;
    vec++; if (bus.data !== mdl[widx(32'h100)]) begin err++; $display("FAIL mid_read_drive: got %h expected %h", bus.data, mdl[widx(32'h100)]); end
    #2 reset = 0; #1;
    vec++; if (!released(bus.data)) begin err++; $display("FAIL mid_read_release: got %h expected z", bus.data); end
    vec++; if (console_valid !== 1'b0) begin err++; $display("FAIL mid_read_valid: got %b expected 0", console_valid); end
    en = 0;
    @(posedge CLK); #1;
    reset = 1;
    q.delete();
    ovf = 0;
    access(0, 32'h100, 4'hf, 0, rd, af);
    vec++; if (rd !== mdl[widx(32'h100)]) begin err++; $display("FAIL post_reset_ram: got %h expected %h", rd, mdl[widx(32'h100)]); end
    access(0, CON, 4'hf, 0, rd, af);
    vec++; if (rd !== 32'h2) begin err++; $display("FAIL post_reset_status: got %h expected 00000002", rd); end
  endtask
  task automatic test_out_of_range();
    logic [31:0] rd, af, w0;
    w0 = mdl[0];
`ifdef PHOENIX_DMEM_FAULT_EN
    access(1, 32'(4 * MEM_DEPTH), 4'hf, 32'h12345678, rd, af);
    vec++; if (access_fault !== 1'b1) begin err++; $display("FAIL fault_flag: got %b expected 1", access_fault); end
    access(0, 32'h0, 4'hf, 0, rd, af);
    vec++; if (rd !== w0) begin err++; $display("FAIL fault_nowrite: got %h expected %h", rd, w0); end
    access(0, 32'(4 * MEM_DEPTH), 4'hf, 0, rd, af);
    vec++; if (rd !== 32'h0) begin err++; $display("FAIL fault_read: got %h expected 00000000", rd); end
`else
    ram_write(32'(4 * MEM_DEPTH), 4'hf, 32'h12345678);
    access(0, 32'h0, 4'hf, 0, rd, af);
    vec++; if (rd !== 32'h12345678) begin err++; $display("FAIL wrap_write: got %h expected 12345678 (old %h)", rd, w0); end
    access(0, 32'(4 * MEM_DEPTH + 4), 4'hf, 0, rd, af);
    vec++; if (rd !== mdl[1]) begin err++; $display("FAIL wrap_read: got %h expected %h", rd, mdl[1]); end
`endif
  endtask
  initial begin
    CLK = 0; reset = 1; console_ready = 0; en = 0; st = 0; drv = 0;
    addr = 0; wdata = 0; mask = 0; vec = 0; err = 0; ovf = 0;
    #1 reset = 0;
    test_reset();
    test_write_read();
    test_random_ram();
    test_console();
    test_overflow();
    test_full_push_pop();
    test_random_console();
    ram_write(32'h4, 4'hf, 32'h0BADF00D);
    test_reset_mid_read();
    test_out_of_range();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
